// File: rtl/mdio_resp_pkg.sv
// Shared definitions for the Clause-22 MDIO PHY responder.
//   - mdio_state_e : frame decoder states
//   - OP_READ/OP_WRITE : two-bit opcodes following the start bits
//   - REG_* : indices of the fixed-function registers
//   - STAT_BASE : status register value before the live/config bits are merged
package mdio_resp_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDRIVE
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_STAT = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;

  localparam logic [DATA_W-1:0] STAT_BASE = 16'h7849;

  // Preamble length that arms the start-of-frame detector.
  localparam logic [5:0] PREAMBLE_MIN = 6'd32;

endpackage

// File: rtl/mdio_resp_sync.sv
// Brings MDC and MDIO into the clk domain.
//   clk      : system clock (at least 8x MDC)
//   rst      : synchronous active-high reset (edge detector only)
//   mdc      : asynchronous management clock
//   mdio_in  : asynchronous resolved MDIO bus value
//   bit_vld  : one-clk pulse on each synchronized MDC rising edge
//   bit_val  : synchronized MDIO value, valid while bit_vld is high
module mdio_resp_sync (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio_in,
  output logic bit_vld,
  output logic bit_val
);

  logic mdc_p0, mdc_p1, mdc_p2;
  logic mdio_p0, mdio_p1;

  // Stage p0/p1: two-flop synchronizers; p2: previous MDC level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_p0 <= 1'b0;
      mdc_p1 <= 1'b0;
      mdc_p2 <= 1'b0;
    end else begin
      mdc_p0 <= mdc;
      mdc_p1 <= mdc_p0;
      mdc_p2 <= mdc_p1;
    end
  end

  always_ff @(posedge clk) begin
    mdio_p0 <= mdio_in;
    mdio_p1 <= mdio_p0;
  end

  // MDIO and MDC travel through matched depths, so the data bit seen with the
  // edge pulse is the one that was stable around the physical MDC rise.
  assign bit_vld = mdc_p1 & ~mdc_p2;
  assign bit_val = mdio_p1;

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target serving an emulated 32x16 PHY register file.
//   clk_clk     : system clock (at least 8x MDC)
//   reset_reset : synchronous active-high reset
//   mdc         : management clock from the MAC (asynchronous)
//   mdio_in     : resolved MDIO bus value
//   mdio_out    : value driven onto MDIO (0 while released)
//   mdio_oen    : active-low output enable, 1 = released
//   link_up     : link status, shown in reg1 bit 2
//   ctrl_reg    : current reg0 value
// Build option: define MDIO_RESP_PREAMBLE_SUPPRESS_EN to accept a start
// sequence after any number of preamble ones; reg1 bit 6 then reads 1.
module mdio_phy_responder
  import mdio_resp_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter logic [31:0] PHY_ID   = 32'h0141_0DD0,
  parameter logic [15:0] CTRL_RST = 16'h1140
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        link_up,
  output logic [15:0] ctrl_reg
);

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic SUPPRESS = 1'b1;
`else
  localparam logic SUPPRESS = 1'b0;
`endif

  // Bit 15 is self-clearing, so it never lives in storage.
  localparam logic [DATA_W-1:0] CTRL_INIT = CTRL_RST & 16'h7FFF;

  logic bit_vld, bit_val;

  mdio_state_e       state_q, state_d;
  logic [5:0]        pre_cnt_q, pre_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        addr_sr_q, addr_sr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d;
  logic              oen_q, oen_d;
  logic              out_q, out_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] regs [0:31];
  logic [4:0]        regad_full;
  logic [DATA_W-1:0] rd_word;
  logic              preamble_ok;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

  function automatic logic reg_is_rw(input logic [4:0] a);
    return (a == REG_CTRL) || (a > REG_ID2);
  endfunction

  function automatic logic [DATA_W-1:0] reg_read(input logic [4:0]        a,
                                                  input logic              lnk,
                                                  input logic [DATA_W-1:0] rw_val);
    logic [DATA_W-1:0] v;
    case (a)
      REG_STAT: v = (STAT_BASE & ~16'h0044) | {9'd0, SUPPRESS, 3'd0, lnk, 2'd0};
      REG_ID1:  v = PHY_ID[31:16];
      REG_ID2:  v = PHY_ID[15:0];
      default:  v = rw_val;
    endcase
    return v;
  endfunction

  mdio_resp_sync u_sync (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .mdc     (mdc),
    .mdio_in (mdio_in),
    .bit_vld (bit_vld),
    .bit_val (bit_val)
  );

  assign preamble_ok = SUPPRESS | (pre_cnt_q >= PREAMBLE_MIN);
  assign regad_full  = {addr_sr_q[3:0], bit_val};
  assign rd_word     = reg_read(regad_full, link_up, regs[regad_full]);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    op_d      = op_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    oen_d     = oen_q;
    out_d     = out_q;
    wr_en_d   = 1'b0;
    if (bit_vld) begin
      case (state_q)
        IDLE: begin
          if (bit_val) begin
            pre_cnt_d = sat_inc6(pre_cnt_q);
          end else begin
            pre_cnt_d = 6'd0;
            if (preamble_ok) state_d = START;
          end
        end
        START: begin
          bit_cnt_d = 5'd0;
          state_d   = bit_val ? OP : IDLE;
        end
        OP: begin
          op_d = {op_q[0], bit_val};
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = 5'd0;
            state_d   = (op_d == OP_READ || op_d == OP_WRITE) ? PHYAD : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        PHYAD: begin
          addr_sr_d = {addr_sr_q[3:0], bit_val};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            // A frame for another PHY is abandoned; the bus is never touched.
            state_d   = (addr_sr_d == PHY_ADDR) ? REGAD : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        REGAD: begin
          addr_sr_d = regad_full;
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            state_d   = TA;
            // Snapshot read data now so fabric changes mid-frame are not seen.
            if (op_q == OP_READ) data_sr_d = rd_word;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        TA: begin
          if (op_q == OP_READ) begin
            // First TA bit is the master's Z; we drive the second TA bit low.
            oen_d     = 1'b0;
            out_d     = 1'b0;
            bit_cnt_d = 5'd0;
            state_d   = RDRIVE;
          end else if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
            if (!bit_val) state_d = IDLE;
          end else begin
            bit_cnt_d = 5'd0;
            state_d   = bit_val ? IDLE : WDATA;
          end
        end
        WDATA: begin
          data_sr_d = {data_sr_q[14:0], bit_val};
          if (bit_cnt_q == 5'd15) begin
            bit_cnt_d = 5'd0;
            wr_en_d   = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        RDRIVE: begin
          if (bit_cnt_q == 5'd16) begin
            oen_d     = 1'b1;
            out_d     = 1'b0;
            bit_cnt_d = 5'd0;
            state_d   = IDLE;
          end else begin
            out_d     = data_sr_q[15];
            data_sr_d = {data_sr_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame decoder control state
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      pre_cnt_q <= 6'd0;
      bit_cnt_q <= 5'd0;
      oen_q     <= 1'b1;
      out_q     <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      oen_q     <= oen_d;
      out_q     <= out_d;
      wr_en_q   <= wr_en_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    op_q      <= op_d;
    addr_sr_q <= addr_sr_d;
    data_sr_q <= data_sr_d;
  end

  // Register file write, one clk after the last data bit; address and data
  // stay put in the shift registers because the next MDC edge is far away.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? CTRL_INIT : 16'h0000;
    end else if (wr_en_q) begin
      if (addr_sr_q == REG_CTRL && data_sr_q[15]) begin
        for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? CTRL_INIT : 16'h0000;
      end else if (reg_is_rw(addr_sr_q)) begin
        regs[addr_sr_q] <= (addr_sr_q == REG_CTRL) ? (data_sr_q & 16'h7FFF) : data_sr_q;
      end
    end
  end

  assign mdio_oen = oen_q;
  assign mdio_out = out_q & ~oen_q;
  assign ctrl_reg = regs[0];

endmodule

// File: tb/tb_mdio_phy_responder.sv
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic        link_up;
  logic [15:0] ctrl_reg;

  logic m_en, m_val;
  logic any_drive;
  int   n_total = 0;
  int   n_pass  = 0;

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic [15:0] STAT_L0 = 16'h7849;
  localparam logic [15:0] STAT_L1 = 16'h784D;
  localparam logic        SHORT_PRE_ANSWERED = 1'b1;
`else
  localparam logic [15:0] STAT_L0 = 16'h7809;
  localparam logic [15:0] STAT_L1 = 16'h780D;
  localparam logic        SHORT_PRE_ANSWERED = 1'b0;
`endif

  always #5 clk = ~clk;

  // Open-drain style bus: master, responder, or pull-up.
  assign mdio_in = m_en ? m_val : (mdio_oen ? 1'b1 : mdio_out);

  mdio_phy_responder dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .mdc         (mdc),
    .mdio_in     (mdio_in),
    .mdio_out    (mdio_out),
    .mdio_oen    (mdio_oen),
    .link_up     (link_up),
    .ctrl_reg    (ctrl_reg)
  );

  typedef struct {
    logic        is_wr;
    logic        answer;
    logic        link;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_ctrl;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // One MDC period: master value set during low phase, sample taken just
  // before the rising edge, i.e. what the responder shows after the prior edge.
  task automatic mdc_cycle(input logic en, input logic val, output logic s_oen, output logic s_out);
    m_en  = en;
    m_val = val;
    repeat (8) @(negedge clk);
    s_oen = mdio_oen;
    s_out = mdio_out;
    if (!mdio_oen) any_drive = 1'b1;
    mdc = 1'b1;
    repeat (8) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic a, b;
    for (int i = n - 1; i >= 0; i--) mdc_cycle(1'b1, v[i], a, b);
  endtask

  task automatic send_header(input int pre, input logic is_wr, input logic [4:0] phy, input logic [4:0] ra);
    for (int i = 0; i < pre; i++) send_bits(32'h1, 1);
    send_bits({18'd0, 2'b01, (is_wr ? 2'b01 : 2'b10), phy, ra}, 14);
  endtask

  task automatic do_frame(input int pre, input logic is_wr, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] wdata,
                          output logic [18:0] so, output logic [18:0] sd);
    logic a, b;
    so = '1;
    sd = '0;
    send_header(pre, is_wr, phy, ra);
    if (is_wr) begin
      send_bits({14'd0, 2'b10, wdata}, 18);
      mdc_cycle(1'b0, 1'b1, a, b);
    end else begin
      for (int i = 0; i < 19; i++) mdc_cycle(1'b0, 1'b1, so[i], sd[i]);
    end
  endtask

  task automatic check_read(input string tag, input logic [18:0] so, input logic [18:0] sd,
                            input logic [15:0] exp);
    logic [15:0] rd;
    for (int k = 0; k < 16; k++) rd[15-k] = sd[2+k];
    check({tag, " ta1_released"}, {31'd0, so[0]}, 32'd1);
    check({tag, " ta2_drive0"}, {30'd0, so[1], sd[1]}, 32'd0);
    check({tag, " rdata"}, {16'd0, rd}, {16'd0, exp});
    check({tag, " release_after_d0"}, {31'd0, so[18]}, 32'd1);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench ran past its cycle budget");
    $fatal(1);
  end

  initial begin
    logic [18:0] so, sd;
    logic a, b;

    vec[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd2,  16'h0000, 16'h0141, 16'h1140};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd3,  16'h0000, 16'h0DD0, 16'h1140};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd17, 16'hBEEF, 16'h0000, 16'h1140};
    vec[3]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd17, 16'h0000, 16'hBEEF, 16'h1140};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd3,  16'h1234, 16'h0000, 16'h1140};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd3,  16'h0000, 16'h0DD0, 16'h1140};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 5'd1, 5'd2,  16'h0000, 16'h0000, 16'h1140};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd2,  16'h0000, 16'h0141, 16'h1140};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd1,  16'h0000, STAT_L0,  16'h1140};
    vec[9]  = '{1'b0, 1'b1, 1'b1, 5'd0, 5'd1,  16'h0000, STAT_L1,  16'h1140};
    vec[10] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0,  16'h0100, 16'h0000, 16'h0100};
    vec[11] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0,  16'h0000, 16'h0100, 16'h0100};
    vec[12] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0,  16'h8000, 16'h0000, 16'h1140};
    vec[13] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0,  16'h0000, 16'h1140, 16'h1140};
    vec[14] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd17, 16'h0000, 16'h0000, 16'h1140};
    vec[15] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd31, 16'hA5A5, 16'h0000, 16'h1140};
    vec[16] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd31, 16'h0000, 16'hA5A5, 16'h1140};
    vec[17] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd1,  16'hFFFF, 16'h0000, 16'h1140};
    vec[18] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd1,  16'h0000, STAT_L0,  16'h1140};
    vec[19] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0,  16'h2100, 16'h0000, 16'h2100};

    rst     = 1'b1;
    mdc     = 1'b0;
    m_en    = 1'b1;
    m_val   = 1'b1;
    link_up = 1'b0;
    any_drive = 1'b0;
    repeat (4) @(negedge clk);
    check("reset oen", {31'd0, mdio_oen}, 32'd1);
    check("reset out", {31'd0, mdio_out}, 32'd0);
    check("reset ctrl_reg", {16'd0, ctrl_reg}, 32'h1140);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      link_up   = vec[i].link;
      any_drive = 1'b0;
      do_frame(32, vec[i].is_wr, vec[i].phy, vec[i].ra, vec[i].wdata, so, sd);
      if (!vec[i].is_wr && vec[i].answer)
        check_read($sformatf("vec%0d", i), so, sd, vec[i].exp_rd);
      else
        check($sformatf("vec%0d bus_untouched", i), {31'd0, any_drive}, 32'd0);
      check($sformatf("vec%0d ctrl_reg", i), {16'd0, ctrl_reg}, {16'd0, vec[i].exp_ctrl});
    end
    link_up = 1'b0;

    // 31-bit preamble; the leading 0 clears whatever the previous idle bits counted.
    mdc_cycle(1'b1, 1'b0, a, b);
    any_drive = 1'b0;
    do_frame(31, 1'b0, 5'd0, 5'd2, 16'h0000, so, sd);
    if (SHORT_PRE_ANSWERED) check_read("short_pre", so, sd, 16'h0141);
    else check("short_pre ignored", {31'd0, any_drive}, 32'd0);

    // A full-preamble read must still be answered afterwards.
    do_frame(32, 1'b0, 5'd0, 5'd3, 16'h0000, so, sd);
    check_read("after_short_pre", so, sd, 16'h0DD0);

    // Reset while D7 of a read is on the bus.
    send_header(32, 1'b0, 5'd0, 5'd2);
    for (int i = 0; i < 10; i++) mdc_cycle(1'b0, 1'b1, a, b);
    check("mid_read driving d7 oen", {31'd0, mdio_oen}, 32'd0);
    check("mid_read d7 value", {31'd0, mdio_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_read reset oen", {31'd0, mdio_oen}, 32'd1);
    check("mid_read reset out", {31'd0, mdio_out}, 32'd0);
    rst = 1'b0;
    check("mid_read reset ctrl_reg", {16'd0, ctrl_reg}, 32'h1140);
    repeat (2) @(negedge clk);
    do_frame(32, 1'b0, 5'd0, 5'd2, 16'h0000, so, sd);
    check_read("after_reset", so, sd, 16'h0141);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
